// File: rtl/fmmu_pkg.sv
// fmmu_pkg: shared record layout, type-bit positions and decoded record type
// for the FMMU translator.
package fmmu_pkg;

    // Byte offsets inside one 16-byte FMMU record (little-endian fields).
    localparam int unsigned FMMU_OFS_LSTART = 0;
    localparam int unsigned FMMU_OFS_LEN    = 4;
    localparam int unsigned FMMU_OFS_SBIT   = 6;
    localparam int unsigned FMMU_OFS_EBIT   = 7;
    localparam int unsigned FMMU_OFS_PSTART = 8;
    localparam int unsigned FMMU_OFS_PBIT   = 10;
    localparam int unsigned FMMU_OFS_TYPE   = 11;
    localparam int unsigned FMMU_OFS_ACT    = 12;

    // Bytes 0x0..0xC hold state; 0xD..0xF are reserved and never stored.
    localparam int unsigned FMMU_REC_USED   = FMMU_OFS_ACT + 1;

    // Bit positions inside the type byte.
    localparam int unsigned FMMU_TYPE_RD = 0;
    localparam int unsigned FMMU_TYPE_WR = 1;

    typedef struct packed {
        logic [31:0] lstart;
        logic [15:0] len;
        logic [7:0]  sbit;
        logic [7:0]  ebit;
        logic [15:0] pstart;
        logic [7:0]  pbit;
        logic [7:0]  typ;
        logic [7:0]  act;
    } fmmu_cfg_t;

    // Assemble the little-endian record bytes into named fields.
    function automatic fmmu_cfg_t fmmu_decode(input logic [FMMU_REC_USED-1:0][7:0] rec);
        fmmu_cfg_t d;
        d.lstart = {rec[FMMU_OFS_LSTART+3], rec[FMMU_OFS_LSTART+2],
                    rec[FMMU_OFS_LSTART+1], rec[FMMU_OFS_LSTART]};
        d.len    = {rec[FMMU_OFS_LEN+1], rec[FMMU_OFS_LEN]};
        d.sbit   = rec[FMMU_OFS_SBIT];
        d.ebit   = rec[FMMU_OFS_EBIT];
        d.pstart = {rec[FMMU_OFS_PSTART+1], rec[FMMU_OFS_PSTART]};
        d.pbit   = rec[FMMU_OFS_PBIT];
        d.typ    = rec[FMMU_OFS_TYPE];
        d.act    = rec[FMMU_OFS_ACT];
        return d;
    endfunction

endpackage

// File: rtl/fmmu_chan_cmp.sv
// fmmu_chan_cmp: per-channel window compare. Purely combinational; produces
// the in-window hit and the unsigned offset of the request into the window.
module fmmu_chan_cmp
    import fmmu_pkg::*;
#(
    parameter int unsigned LADDR_W = 32
) (
    input  fmmu_cfg_t            cfg,
    input  logic [LADDR_W-1:0]   req_laddr,
    input  logic                 req_wr,
    output logic                 hit,
    output logic [LADDR_W-1:0]   off
);

    logic dir_ok;
    logic unused_cfg;

    // Offset wraps for addresses below lstart, so a single compare covers both ends.
    always_comb begin
        off        = req_laddr - LADDR_W'(cfg.lstart);
        dir_ok     = req_wr ? cfg.typ[FMMU_TYPE_WR] : cfg.typ[FMMU_TYPE_RD];
        hit        = cfg.act[0] && dir_ok && (off < LADDR_W'(cfg.len));
        unused_cfg = ^{cfg.sbit, cfg.ebit, cfg.pstart, cfg.pbit, cfg.typ[7:2], cfg.act[7:1]};
    end

endmodule

// File: rtl/fmmu_xlate.sv
// fmmu_xlate: multi-channel FMMU logical-to-physical translator with a
// byte-addressed record file and a 2-stage back-pressured pipeline.
// Optional feature macro: FMMU_BITMASK_EN (per-byte start/end bit mask).
module fmmu_xlate
    import fmmu_pkg::*;
#(
    parameter int unsigned NUM_FMMU = 4,
    parameter int unsigned LADDR_W  = 32,
    parameter int unsigned PADDR_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_idx,
    input  logic [3:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic [7:0]           cfg_rdata,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [LADDR_W-1:0]   req_laddr,
    input  logic                 req_wr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_hit,
    output logic                 rsp_multi,
    output logic [3:0]           rsp_chan,
    output logic [PADDR_W-1:0]   rsp_paddr,
    output logic [7:0]           rsp_mask
);

    logic [NUM_FMMU-1:0][FMMU_REC_USED-1:0][7:0] regs;
    fmmu_cfg_t            cfg   [NUM_FMMU];
    logic [NUM_FMMU-1:0]  c_hit;
    logic [LADDR_W-1:0]   c_off [NUM_FMMU];
    logic [7:0]           rd_byte;
    logic                 advance;

    logic                 s1_valid;
    logic [NUM_FMMU-1:0]  s1_hit;
    logic [LADDR_W-1:0]   s1_off    [NUM_FMMU];
    logic [PADDR_W-1:0]   s1_pstart [NUM_FMMU];
`ifdef FMMU_BITMASK_EN
    logic [NUM_FMMU-1:0]  s1_first;
    logic [NUM_FMMU-1:0]  s1_last;
    logic [2:0]           s1_sbit   [NUM_FMMU];
    logic [2:0]           s1_ebit   [NUM_FMMU];
    logic                 w_first;
    logic                 w_last;
    logic [2:0]           w_sbit;
    logic [2:0]           w_ebit;
`endif

    logic                 found;
    int unsigned          cnt;
    logic [3:0]           w_chan;
    logic [LADDR_W-1:0]   w_off;
    logic [PADDR_W-1:0]   w_pstart;
    logic [7:0]           m;
    logic                 n_hit;
    logic                 n_multi;
    logic [3:0]           n_chan;
    logic [PADDR_W-1:0]   n_paddr;
    logic [7:0]           n_mask;
    logic                 unused_off;

    // Record file byte writes; out-of-range index and reserved bytes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < NUM_FMMU; i++) begin
                for (int unsigned b = 0; b < FMMU_REC_USED; b++) begin
                    if (cfg_idx == 4'(i) && cfg_addr == 4'(b)) begin
                        regs[i][b] <= cfg_wdata;
                    end
                end
            end
        end
    end

    // Read mux; unmapped index/offset combinations fall through to zero.
    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < NUM_FMMU; i++) begin
            for (int unsigned b = 0; b < FMMU_REC_USED; b++) begin
                if (cfg_idx == 4'(i) && cfg_addr == 4'(b)) begin
                    rd_byte = regs[i][b];
                end
            end
        end
    end

    // Registered read data (old value wins on a same-cycle write).
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata <= '0;
        end else begin
            cfg_rdata <= rd_byte;
        end
    end

    // Decode every record into named fields for the comparators.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FMMU; i++) begin
            cfg[i] = fmmu_decode(regs[i]);
        end
    end

    for (genvar g = 0; g < NUM_FMMU; g++) begin : g_chan
        fmmu_chan_cmp #(
            .LADDR_W (LADDR_W)
        ) u_cmp (
            .cfg       (cfg[g]),
            .req_laddr (req_laddr),
            .req_wr    (req_wr),
            .hit       (c_hit[g]),
            .off       (c_off[g])
        );
    end

    // Stage 1 may load whenever stage 2 drains or stage 1 is empty.
    always_comb begin
        advance   = !rsp_valid || rsp_ready;
        req_ready = advance || !s1_valid;
    end

    // Stage 1 occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (req_ready) begin
            s1_valid <= req_valid;
        end
    end

    // Stage 1 payload; the config fields stage 2 needs are snapshotted here so a
    // config write after acceptance cannot leak into this request's response.
    always_ff @(posedge clk) begin
        if (req_ready) begin
            s1_hit <= c_hit;
            for (int unsigned i = 0; i < NUM_FMMU; i++) begin
                s1_off[i]    <= c_off[i];
                s1_pstart[i] <= PADDR_W'(cfg[i].pstart);
`ifdef FMMU_BITMASK_EN
                s1_first[i]  <= (c_off[i] == '0);
                s1_last[i]   <= (c_off[i] == (LADDR_W'(cfg[i].len) - LADDR_W'(1)));
                s1_sbit[i]   <= cfg[i].sbit[2:0];
                s1_ebit[i]   <= cfg[i].ebit[2:0];
`endif
            end
        end
    end

    // Stage 2: lowest-index priority select, hit count, address add and mask.
    always_comb begin
        found    = 1'b0;
        cnt      = 0;
        w_chan   = '0;
        w_off    = '0;
        w_pstart = '0;
`ifdef FMMU_BITMASK_EN
        w_first  = 1'b0;
        w_last   = 1'b0;
        w_sbit   = '0;
        w_ebit   = '0;
`endif
        for (int unsigned i = 0; i < NUM_FMMU; i++) begin
            if (s1_valid && s1_hit[i]) begin
                cnt = cnt + 1;
                if (!found) begin
                    found    = 1'b1;
                    w_chan   = 4'(i);
                    w_off    = s1_off[i];
                    w_pstart = s1_pstart[i];
`ifdef FMMU_BITMASK_EN
                    w_first  = s1_first[i];
                    w_last   = s1_last[i];
                    w_sbit   = s1_sbit[i];
                    w_ebit   = s1_ebit[i];
`endif
                end
            end
        end
        m = 8'hFF;
`ifdef FMMU_BITMASK_EN
        if (w_first) m = m & (8'hFF << w_sbit);
        if (w_last)  m = m & (8'hFF >> (3'd7 - w_ebit));
`endif
        n_hit   = found;
        n_multi = (cnt > 1);
        n_chan  = found ? w_chan : '0;
        n_paddr = found ? (w_pstart + PADDR_W'(w_off)) : '0;
        n_mask  = found ? m : '0;
    end

    // Upper offset bits only matter to the comparators, not to the response.
    always_comb begin
        unused_off = 1'b0;
        for (int unsigned i = 0; i < NUM_FMMU; i++) begin
            unused_off = unused_off ^ (^s1_off[i]);
        end
    end

    // Response register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_multi <= 1'b0;
            rsp_chan  <= '0;
            rsp_paddr <= '0;
            rsp_mask  <= '0;
        end else if (advance) begin
            rsp_valid <= s1_valid;
            rsp_hit   <= n_hit;
            rsp_multi <= n_multi;
            rsp_chan  <= n_chan;
            rsp_paddr <= n_paddr;
            rsp_mask  <= n_mask;
        end
    end

endmodule

// File: tb/tb_fmmu_xlate.sv
// tb_fmmu_xlate: scoreboard bench for fmmu_xlate (directed vectors).
module tb_fmmu_xlate;

    localparam int unsigned NUM_FMMU = 4;
    localparam int unsigned LADDR_W  = 32;
    localparam int unsigned PADDR_W  = 16;

`ifdef FMMU_BITMASK_EN
    localparam logic [7:0] MK0 = 8'hF8, MK1 = 8'hFF, MK2 = 8'h3F, MK_ONE = 8'h38;
`else
    localparam logic [7:0] MK0 = 8'hFF, MK1 = 8'hFF, MK2 = 8'hFF, MK_ONE = 8'hFF;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [3:0]         cfg_idx;
    logic [3:0]         cfg_addr;
    logic [7:0]         cfg_wdata;
    logic [7:0]         cfg_rdata;
    logic               req_valid;
    logic               req_ready;
    logic [LADDR_W-1:0] req_laddr;
    logic               req_wr;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_hit;
    logic               rsp_multi;
    logic [3:0]         rsp_chan;
    logic [PADDR_W-1:0] rsp_paddr;
    logic [7:0]         rsp_mask;

    fmmu_xlate #(
        .NUM_FMMU (NUM_FMMU),
        .LADDR_W  (LADDR_W),
        .PADDR_W  (PADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_laddr (req_laddr),
        .req_wr    (req_wr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_multi (rsp_multi),
        .rsp_chan  (rsp_chan),
        .rsp_paddr (rsp_paddr),
        .rsp_mask  (rsp_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        hit;
        logic        multi;
        logic [3:0]  chan;
        logic [15:0] paddr;
        logic [7:0]  mask;
        bit          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   rdy_rand = 1'b0;

    function automatic exp_t ex(logic h, logic mu, logic [3:0] c, logic [15:0] p,
                                logic [7:0] k, string nm);
        exp_t e;
        e.hit = h; e.multi = mu; e.chan = c; e.paddr = p; e.mask = k;
        e.lat = 1'b0; e.acc = 0; e.name = nm;
        return e;
    endfunction

    function automatic exp_t miss(string nm);
        return ex(1'b0, 1'b0, 4'd0, 16'h0000, 8'h00, nm);
    endfunction

    // Consumer-side ready: steady 1, or random while back-pressure is exercised.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each response handshake and checks hold
    // stability of outputs across a stalled cycle.
    logic        prev_stall = 1'b0;
    logic [29:0] held;
    always @(negedge clk) begin
        logic [29:0] got;
        logic [29:0] want;
        exp_t        e;
        got = {rsp_hit, rsp_multi, rsp_chan, rsp_paddr, rsp_mask};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_chk++;
                if (!rsp_valid || got !== held) begin
                    n_fail++;
                    $display("FAIL hold: got valid=%0b fields=%h, required valid=1 fields=%h",
                             rsp_valid, got, held);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: got fields=%h, required no response", got);
                end else begin
                    e    = q.pop_front();
                    want = {e.hit, e.multi, e.chan, e.paddr, e.mask};
                    if (got !== want || (e.lat && (cyc - e.acc) != 2)) begin
                        n_fail++;
                        $display("FAIL %s: got hit=%0b multi=%0b chan=%0d paddr=%h mask=%h lat=%0d, required hit=%0b multi=%0b chan=%0d paddr=%h mask=%h lat=2",
                                 e.name, rsp_hit, rsp_multi, rsp_chan, rsp_paddr, rsp_mask,
                                 cyc - e.acc, e.hit, e.multi, e.chan, e.paddr, e.mask);
                    end
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            held       = got;
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_check(input logic [3:0] idx, input logic [3:0] a, input logic [7:0] want,
                             input string nm);
        cfg_idx = idx; cfg_addr = a;
        @(posedge clk);
        #1;
        check(nm, 32'(cfg_rdata), 32'(want));
    endtask

    task automatic write_rec(input logic [3:0] idx, input logic [31:0] ls, input logic [15:0] len,
                             input logic [7:0] sb, input logic [7:0] eb, input logic [15:0] ps,
                             input logic [7:0] ty, input logic [7:0] act);
        cfg_write(idx, 4'h0, ls[7:0]);
        cfg_write(idx, 4'h1, ls[15:8]);
        cfg_write(idx, 4'h2, ls[23:16]);
        cfg_write(idx, 4'h3, ls[31:24]);
        cfg_write(idx, 4'h4, len[7:0]);
        cfg_write(idx, 4'h5, len[15:8]);
        cfg_write(idx, 4'h6, sb);
        cfg_write(idx, 4'h7, eb);
        cfg_write(idx, 4'h8, ps[7:0]);
        cfg_write(idx, 4'h9, ps[15:8]);
        cfg_write(idx, 4'hA, 8'h00);
        cfg_write(idx, 4'hB, ty);
        cfg_write(idx, 4'hC, act);
    endtask

    // Issue one request; the expected response is queued at the handshake.
    task automatic send(input logic [31:0] la, input logic wr, input exp_t e);
        bit ok = 1'b0;
        req_laddr = la; req_wr = wr; req_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) begin
                e.lat = !rdy_rand;
                e.acc = cyc;
                q.push_back(e);
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout %s: got req_ready=0 for 200 cycles, required 1", e.name);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 500; k++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [127:0] rbv;
    exp_t         er;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_wdata = '0;
        req_valid = 1'b0; req_laddr = '0; req_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_fields", 32'({rsp_hit, rsp_multi, rsp_chan, rsp_paddr, rsp_mask}), 32'd0);
        check("rst_rdata", 32'(cfg_rdata), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);

        // Record write / read-back, reserved bytes and out-of-range index.
        write_rec(4'd0, 32'h0001_0000, 16'd4, 8'h00, 8'h07, 16'h1000, 8'h03, 8'h01);
        cfg_write(4'd0, 4'hD, 8'hAA);
        cfg_write(4'd4, 4'h0, 8'h55);
        rbv = 128'h00000001_03001000_07000004_00010000;
        for (int b = 0; b < 16; b++) begin
            cfg_check(4'd0, 4'(b), rbv[8*b +: 8], $sformatf("readback_b%0d", b));
        end
        cfg_check(4'd4, 4'h0, 8'h00, "idx_oor_read");

        // In-window hit and window end.
        send(32'h0001_0002, 1'b0, ex(1, 0, 4'd0, 16'h1002, 8'hFF, "hit_off2"));
        send(32'h0001_0004, 1'b0, miss("miss_past_end"));
        send(32'h0001_0000, 1'b0, ex(1, 0, 4'd0, 16'h1000, 8'hFF, "hit_off0"));
        drain();

        // Overlap and direction.
        write_rec(4'd1, 32'h0001_0000, 16'd4, 8'h00, 8'h07, 16'h1000, 8'h02, 8'h01);
        send(32'h0001_0001, 1'b1, ex(1, 1, 4'd0, 16'h1001, 8'hFF, "overlap_wr"));
        send(32'h0001_0001, 1'b0, ex(1, 0, 4'd0, 16'h1001, 8'hFF, "overlap_rd"));
        drain();
        cfg_write(4'd0, 4'hC, 8'h00);
        send(32'h0001_0001, 1'b1, ex(1, 0, 4'd1, 16'h1001, 8'hFF, "ch0_off_wr"));
        send(32'h0001_0001, 1'b0, miss("ch0_off_rd"));
        send(32'h0001_0003, 1'b1, ex(1, 0, 4'd1, 16'h1003, 8'hFF, "ch1_last"));

        // Physical wrap, zero length, below-window address.
        write_rec(4'd2, 32'h0002_0000, 16'd4, 8'h00, 8'h07, 16'hFFFE, 8'h03, 8'h01);
        write_rec(4'd3, 32'h0003_0000, 16'd0, 8'h00, 8'h07, 16'h3000, 8'h03, 8'h01);
        send(32'h0002_0003, 1'b0, ex(1, 0, 4'd2, 16'h0001, 8'hFF, "pwrap_off3"));
        send(32'h0002_0002, 1'b0, ex(1, 0, 4'd2, 16'h0000, 8'hFF, "pwrap_off2"));
        send(32'h0003_0000, 1'b0, miss("len0"));
        send(32'h0001_FFFF, 1'b1, miss("below_lstart"));
        drain();

        // Bit mask: start bit 3, end bit 5.
        write_rec(4'd2, 32'h0004_0000, 16'd3, 8'h03, 8'h05, 16'h2000, 8'h03, 8'h01);
        send(32'h0004_0000, 1'b0, ex(1, 0, 4'd2, 16'h2000, MK0, "mask_off0"));
        send(32'h0004_0001, 1'b0, ex(1, 0, 4'd2, 16'h2001, MK1, "mask_off1"));
        send(32'h0004_0002, 1'b0, ex(1, 0, 4'd2, 16'h2002, MK2, "mask_off2"));
        drain();
        cfg_write(4'd2, 4'h4, 8'h01);
        send(32'h0004_0000, 1'b0, ex(1, 0, 4'd2, 16'h2000, MK_ONE, "mask_len1"));
        send(32'h0004_0001, 1'b0, miss("len1_off1"));
        drain();

        // Back-to-back stream under random back-pressure.
        cfg_write(4'd0, 4'hC, 8'h01);
        rdy_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int unsigned k;
            logic        w;
            k = i % 5;
            w = 1'(i % 2);
            if (k < 4) er = ex(1, w, 4'd0, 16'h1000 + 16'(k), 8'hFF, $sformatf("stream_%0d", i));
            else       er = miss($sformatf("stream_%0d", i));
            send(32'h0001_0000 + k, w, er);
        end
        drain();
        rdy_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Config write in the acceptance cycle is invisible to that request.
        req_laddr = 32'h0001_0001; req_wr = 1'b0; req_valid = 1'b1;
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_addr = 4'hC; cfg_wdata = 8'h00;
        @(negedge clk);
        check("race_ready", 32'(req_ready), 32'd1);
        er = ex(1, 0, 4'd0, 16'h1001, 8'hFF, "race_same_cycle");
        er.lat = 1'b1;
        er.acc = cyc;
        q.push_back(er);
        @(posedge clk);
        #1;
        req_valid = 1'b0; cfg_we = 1'b0;
        send(32'h0001_0001, 1'b0, miss("race_next"));
        drain();

        // Reset in the middle of a stalled stream.
        cfg_write(4'd0, 4'hC, 8'h01);
        rdy_rand = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(32'h0001_0000 + 32'(i % 4), 1'b0,
                 ex(1, 0, 4'd0, 16'h1000 + 16'(i % 4), 8'hFF, $sformatf("midrst_%0d", i)));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        rdy_rand = 1'b0;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_fields", 32'({rsp_hit, rsp_multi, rsp_chan, rsp_paddr, rsp_mask}), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        cfg_check(4'd0, 4'hC, 8'h00, "midrst_act_cleared");
        send(32'h0001_0000, 1'b0, miss("post_rst_miss"));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test by 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fmmu_xlate.md
# fmmu_xlate

Multi-channel EtherCAT FMMU translator: holds `NUM_FMMU` FMMU records in a byte-addressed register file and translates a stream of logical-address requests into physical-address responses. Each response carries a hit flag, the winning channel, and an optional per-byte bit mask. It sits between the datagram parser (logical address, read/write direction) and the process-data RAM port. It is a pipelined, back-pressured successor to the single-record combinational mapper.

## Interface
Parameters:
- `NUM_FMMU`, 4: number of FMMU records, range 1..16.
- `LADDR_W`, 32: logical address width.
- `PADDR_W`, 16: physical address width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cfg_we`  in  1  config byte write strobe.
- `cfg_idx`  in  4  FMMU record index.
- `cfg_addr`  in  4  byte offset within the 16-byte record.
- `cfg_wdata`  in  8  write data.
- `cfg_rdata`  out  8  registered read data for `cfg_idx`/`cfg_addr`, valid 1 cycle later.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request ready.
- `req_laddr`  in  `LADDR_W`  logical byte address.
- `req_wr`  in  1  1 = write access, 0 = read access.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response ready.
- `rsp_hit`  out  1  at least one channel matched.
- `rsp_multi`  out  1  more than one channel matched.
- `rsp_chan`  out  4  index of the winning channel.
- `rsp_paddr`  out  `PADDR_W`  physical byte address.
- `rsp_mask`  out  8  bit mask for the byte.

## Operation
- **Record layout (little-endian):**
  - 0x0–0x3 logical start.
  - 0x4–0x5 length in bytes.
  - 0x6 start bit [2:0].
  - 0x7 end bit [2:0].
  - 0x8–0x9 physical start.
  - 0xA physical start bit [2:0].
  - 0xB type: bit0 = read, bit1 = write.
  - 0xC activate, bit0.
  - 0xD–0xF reserved; writes are ignored and reads return 0.
  - Unused bits of 0x6/0x7/0xA/0xB/0xC are stored but ignored by the match logic.
- **Index range:** when `cfg_idx >= NUM_FMMU`, writes are ignored and reads return 0.
- **Channel match:** a channel matches when all of the following hold:
  - activate is set;
  - the type bit for the request direction (`req_wr` selects write, otherwise read) is set;
  - `off = req_laddr - lstart` (unsigned, `LADDR_W` bits) satisfies `off < length`. A length of 0 never matches; an address below lstart wraps to a large `off` and misses.
- **Priority:** the lowest matching index wins. `rsp_multi` = popcount(hits) > 1.
- **Physical address:** `rsp_paddr = pstart + off[PADDR_W-1:0]`, modulo 2^`PADDR_W` (wraps at 0xFFFF→0x0000).
- **Miss:** `rsp_hit`, `rsp_multi`, `rsp_chan`, `rsp_paddr` and `rsp_mask` are all 0.
- **Mask:** computed as defined under Configuration.

## Timing
- **Reset:**
  - all record bytes reset to 0;
  - pipeline is emptied;
  - `rsp_valid`, `rsp_hit`, `rsp_multi`, `rsp_chan`, `rsp_paddr`, `rsp_mask` and `cfg_rdata` reset to 0;
  - `req_ready` is 1 in the cycle after reset deasserts.
  - Reset mid-operation drops all in-flight requests with no response.
- **Pipeline:**
  - Stage 1 registers the request, the per-channel hit vector and the per-channel `off`.
  - Stage 2 performs priority encode, add and mask, and registers the response.
  - Latency is 2 cycles from the handshake (`req_valid && req_ready`) to `rsp_valid`.
  - Throughput is 1 request per cycle.
- **Back-pressure:**
  - `advance = !rsp_valid || rsp_ready`.
  - `req_ready = advance || !s1_valid`.
  - While `rsp_valid && !rsp_ready`, all `rsp_*` outputs hold stable.
  - No request is lost or duplicated.
- **Config/request race:** a request compares against config as registered before its acceptance edge. A `cfg_we` in the same cycle as acceptance is not visible to that request but is visible to the next one.
- **Config access:** `cfg_rdata` reflects the register contents 1 cycle after `cfg_idx`/`cfg_addr` are presented. A read in the same cycle as a write to the same byte returns the old value.

## Configuration
- **`FMMU_BITMASK_EN` defined:**
  - for a hit, `rsp_mask` starts as 0xFF;
  - when `off == 0`, bits below the start bit are cleared;
  - when `off == length-1`, bits above the end bit are cleared;
  - when length is 1, both clears apply.
- **`FMMU_BITMASK_EN` undefined:** `rsp_mask` = 0xFF on a hit and 0 on a miss. Bytes 0x6/0x7/0xA remain readable and writable; no mask logic is built.

## Structure
- Package `fmmu_pkg` holds:
  - localparams for the record byte offsets (`FMMU_OFS_LSTART` … `FMMU_OFS_ACT`);
  - type bit constants `FMMU_TYPE_RD` = 0 and `FMMU_TYPE_WR` = 1;
  - packed struct `fmmu_cfg_t` for the decoded record.
- Sub-module `fmmu_chan_cmp`, one instance per channel: combinational inputs `fmmu_cfg_t`, `req_laddr` and `req_wr`; outputs `hit` and `off`.
- Priority encoder, adder, mask generation and register file stay in `fmmu_xlate`.

## Test plan
- **Write/read-back:** write ch0 with lstart 0x00010000, len 4, pstart 0x1000, type 0x3, act 1; then read every byte back. Expected: values match and 0xD–0xF read 0.
- **In-window hit:** request laddr 0x00010002, rd. Expected 2 cycles later: hit 1, chan 0, paddr 0x1002, multi 0. A request to laddr 0x00010004 misses with all response fields 0.
- **Overlap and direction:** ch1 = ch0 but type write-only. A write to 0x00010001 gives chan 0 with multi 1. With ch0 disabled, the same write gives chan 1 with multi 0, and a read misses.
- **Wrap and length 0:**
  - pstart 0xFFFE, len 4, request offset 3 → paddr 0x0001;
  - len 0 → never hits;
  - laddr < lstart → miss.
- **Bit mask:** with the macro defined, start bit 3, end bit 5, len 3 gives masks 0xF8, 0xFF, 0x3F for offsets 0, 1, 2. With len 1 the mask is 0x38. With the macro undefined, all three masks are 0xFF.
- **Stream under back-pressure:** 20 back-to-back requests with `rsp_ready` toggling randomly. Expected: responses arrive in order and none are lost. A reset asserted mid-stream clears `rsp_valid` the next cycle. A config write in the acceptance cycle is not seen by that request.
